// File: rtl/sort_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sort_pkg
// Purpose  : Shared state encoding, register map and bit positions for the
//            sort_controller Avalon-MM peripheral.
// Revision : 1.0
// ============================================================================
package sort_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMPARE  = 2'd1,
        PASS_END = 2'd2
    } sort_state_t;

    localparam int c_REG_CTRL   = 0;
    localparam int c_REG_STATUS = 1;
    localparam int c_REG_SWAPS  = 2;

    localparam int c_CTRL_START    = 0;
    localparam int c_CTRL_DONE_CLR = 1;

    localparam int c_STAT_BUSY = 0;
    localparam int c_STAT_DONE = 1;
    localparam int c_STAT_IRQ  = 2;

    localparam int c_SWAPS_W = 16;

endpackage
`default_nettype wire

// File: rtl/sort_cmp_swap.sv
`default_nettype none
// ============================================================================
// Module   : sort_cmp_swap
// Purpose  : Unsigned compare of two words; returns them ordered plus a flag
//            saying whether they had to be exchanged.
// Revision : 1.0
// ============================================================================
module sort_cmp_swap #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_lo,
    output logic [W-1:0] o_hi,
    output logic         o_swap
);

    // Strict greater-than keeps equal keys in place, so the sort is stable.
    assign o_swap = (i_a > i_b);
    assign o_lo   = o_swap ? i_b : i_a;
    assign o_hi   = o_swap ? i_a : i_b;

endmodule
`default_nettype wire

// File: rtl/sort_controller.sv
`default_nettype none
// ============================================================================
// Module   : sort_controller
// Purpose  : Avalon-MM slave owning a DEPTH-word buffer and running an
//            in-place bubble sort over it. Macro SORT_IRQ_EN adds an irq output.
// Revision : 1.0
// ============================================================================
module sort_controller
    import sort_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int W     = 32,
    parameter int AW    = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          chipselect,
    input  logic          read,
    input  logic          write,
    input  logic [AW-1:0] address,
    input  logic [31:0]   writedata,
    output logic [31:0]   readdata,
    output logic          busy,
    output logic          done
`ifdef SORT_IRQ_EN
   ,output logic          irq
`endif
);

    localparam int c_IW = $clog2(DEPTH);

    logic [W-1:0]         r_buf [DEPTH];
    sort_state_t          r_state;
    logic [c_IW-1:0]      r_idx;
    logic [c_IW-1:0]      r_pass;
    logic                 r_swapped;
    logic                 r_busy;
    logic                 r_done;
    logic [c_SWAPS_W-1:0] r_swaps;
    logic [31:0]          r_rdata;

    logic [c_IW-1:0] w_off;
    logic            w_reg_sel;
    logic            w_wr;
    logic            w_ctrl_wr;
    logic            w_start;
    logic            w_dclr;
    logic            w_go;
    logic [c_IW-1:0] w_idx_hi;
    logic [c_IW-1:0] w_pass_next;
    logic            w_last_pair;
    logic            w_finish;
    logic [W-1:0]    w_lo;
    logic [W-1:0]    w_hi;
    logic            w_swap;
    logic            w_irq;
    logic [31:0]     w_rd_mux;

    assign w_off       = address[AW-2:0];
    assign w_reg_sel   = address[AW-1];
    assign w_wr        = chipselect & write;
    assign w_ctrl_wr   = w_wr & w_reg_sel & (int'(w_off) == c_REG_CTRL);
    assign w_start     = w_ctrl_wr & writedata[c_CTRL_START];
    assign w_dclr      = w_ctrl_wr & writedata[c_CTRL_DONE_CLR];
    assign w_go        = w_start & (r_state == IDLE);
    assign w_idx_hi    = r_idx + c_IW'(1);
    assign w_pass_next = r_pass + c_IW'(1);
    assign w_last_pair = (r_idx == c_IW'(DEPTH - 2));
    // The final pass is the one that saw no swap, or the (DEPTH-1)th pass.
    assign w_finish    = (r_state == PASS_END) &&
                         (!r_swapped || (w_pass_next == c_IW'(DEPTH - 1)));

    sort_cmp_swap #(.W(W)) u_cmp_swap (
        .i_a    (r_buf[r_idx]),
        .i_b    (r_buf[w_idx_hi]),
        .o_lo   (w_lo),
        .o_hi   (w_hi),
        .o_swap (w_swap)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_pass    <= '0;
            r_swapped <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_swaps   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            if (w_dclr) begin
                r_done <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_go) begin
                        r_state   <= COMPARE;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                        r_swaps   <= '0;
                        r_pass    <= '0;
                        r_idx     <= '0;
                        r_swapped <= 1'b0;
                    end else if (w_wr && !w_reg_sel) begin
                        r_buf[w_off] <= writedata[W-1:0];
                    end
                end
                COMPARE: begin
                    if (w_swap) begin
                        r_buf[r_idx]    <= w_lo;
                        r_buf[w_idx_hi] <= w_hi;
                        r_swapped       <= 1'b1;
                        if (r_swaps != '1) begin
                            r_swaps <= r_swaps + c_SWAPS_W'(1);
                        end
                    end
                    if (w_last_pair) begin
                        r_state <= PASS_END;
                    end else begin
                        r_idx <= w_idx_hi;
                    end
                end
                PASS_END: begin
                    r_pass <= w_pass_next;
                    if (w_finish) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_swapped <= 1'b0;
                        r_idx     <= '0;
                        r_state   <= COMPARE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SORT_IRQ_EN
    logic r_irq;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else if (w_finish) begin
            r_irq <= 1'b1;
        end else if (w_go || w_dclr) begin
            r_irq <= 1'b0;
        end
    end

    assign w_irq = r_irq;
    assign irq   = r_irq;
`else
    assign w_irq = 1'b0;
`endif

    always_comb begin
        w_rd_mux = '0;
        if (!w_reg_sel) begin
            w_rd_mux = 32'(r_buf[w_off]);
        end else if (int'(w_off) == c_REG_STATUS) begin
            w_rd_mux[c_STAT_BUSY] = r_busy;
            w_rd_mux[c_STAT_DONE] = r_done;
            w_rd_mux[c_STAT_IRQ]  = w_irq;
        end else if (int'(w_off) == c_REG_SWAPS) begin
            w_rd_mux = 32'(r_swaps);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (chipselect && read) begin
            r_rdata <= w_rd_mux;
        end
    end

    assign readdata = r_rdata;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sort_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sort_controller
// Purpose  : Scoreboard bench for sort_controller against a rank/inversion
//            reference model; honours SORT_IRQ_EN.
// Revision : 1.0
// ============================================================================
module tb_sort_controller;

    localparam int DEPTH = 8;
    localparam int AW    = 4;
    localparam logic [3:0] c_A_CTRL   = 4'd8;
    localparam logic [3:0] c_A_STATUS = 4'd9;
    localparam logic [3:0] c_A_SWAPS  = 4'd10;
`ifdef SORT_IRQ_EN
    localparam logic [31:0] c_IRQ_BIT = 32'h4;
`else
    localparam logic [31:0] c_IRQ_BIT = 32'h0;
`endif

    typedef logic [31:0] vec_t [DEPTH];
    typedef struct {
        logic [3:0]  addr;
        logic [31:0] exp;
    } rd_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          chipselect;
    logic          read;
    logic          write;
    logic [AW-1:0] address;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic          busy;
    logic          done;
`ifdef SORT_IRQ_EN
    logic          irq;
`endif

    int  checks = 0;
    int  errors = 0;
    int  busy_total = 0;
    logic pend = 1'b0;
    rd_t rq[$];

    sort_controller #(.DEPTH(DEPTH), .W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .busy       (busy),
        .done       (done)
`ifdef SORT_IRQ_EN
       ,.irq        (irq)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Read monitor: a read accepted at a rising edge is compared on the next falling edge.
    always @(posedge clock) pend <= chipselect && read;

    always @(negedge clock) begin
        if (pend) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected got=%h exp=<none>", readdata);
            end else begin
                rd_t e;
                e = rq.pop_front();
                check($sformatf("rd_a%0d", e.addr), readdata, e.exp);
            end
        end
    end

    always @(negedge clock) if (busy === 1'b1) busy_total <= busy_total + 1;

    task automatic idle_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(posedge clock);
        #1;
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [31:0] e);
        rd_t r;
        r.addr = a;
        r.exp  = e;
        rq.push_back(r);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(posedge clock);
        #1;
        chipselect = 1'b0; read = 1'b0;
    endtask

    // Sorted order by stable rank; swap count is the inversion count; passes
    // follow from the largest leftward distance any element must travel.
    task automatic ref_model(input vec_t v, output vec_t s, output int swaps, output int passes);
        int k;
        k = 0;
        swaps = 0;
        for (int i = 0; i < DEPTH; i++) begin
            int pos;
            int left_gt;
            pos = 0;
            left_gt = 0;
            for (int j = 0; j < DEPTH; j++) begin
                if (v[j] < v[i]) pos++;
                if (j < i && v[j] == v[i]) pos++;
                if (j < i && v[j] > v[i]) left_gt++;
            end
            s[pos] = v[i];
            swaps += left_gt;
            if (left_gt > k) k = left_gt;
        end
        passes = (k + 1 > DEPTH - 1) ? DEPTH - 1 : k + 1;
    endtask

    task automatic run_case(input vec_t v, input bit disturb, input logic [31:0] start_val);
        vec_t s;
        int   swaps;
        int   passes;
        int   b0;
        int   n;
        for (int i = 0; i < DEPTH; i++) bus_write(4'(i), v[i]);
        for (int i = 0; i < DEPTH; i++) bus_read(4'(i), v[i]);
        ref_model(v, s, swaps, passes);
        b0 = busy_total;
        bus_write(c_A_CTRL, start_val);
        check("busy_after_start", {31'b0, busy}, 32'h1);
        bus_read(c_A_STATUS, 32'h1);
        if (disturb) begin
            repeat (3) idle_cycle();
            bus_write(4'd0, 32'hDEAD);
            bus_write(c_A_CTRL, 32'h1);
        end
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            idle_cycle();
            n++;
        end
        if (n >= 2000) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout got=busy_stuck exp=completion");
        end
        check("busy_cycles", 32'(busy_total - b0), 32'(passes * DEPTH));
        check("done_set", {31'b0, done}, 32'h1);
`ifdef SORT_IRQ_EN
        check("irq_set", {31'b0, irq}, 32'h1);
`endif
        bus_read(c_A_SWAPS, 32'(swaps));
        bus_read(c_A_STATUS, 32'h2 | c_IRQ_BIT);
        for (int i = 0; i < DEPTH; i++) bus_read(4'(i), s[i]);
        bus_write(c_A_CTRL, 32'h2);
        check("done_clr", {31'b0, done}, 32'h0);
`ifdef SORT_IRQ_EN
        check("irq_clr", {31'b0, irq}, 32'h0);
`endif
        bus_read(c_A_STATUS, 32'h0);
        repeat (2) idle_cycle();
    endtask

    initial begin
        vec_t v;
        reset = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = '0; writedata = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        idle_cycle();

        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_readdata", readdata, 32'h0);
        bus_read(c_A_STATUS, 32'h0);
        bus_read(c_A_SWAPS, 32'h0);
        for (int i = 0; i < DEPTH; i++) bus_read(4'(i), 32'h0);

        for (int i = 0; i < DEPTH; i++) v[i] = 32'(DEPTH - i);
        run_case(v, 1'b0, 32'h1);
        for (int i = 0; i < DEPTH; i++) v[i] = 32'(i + 1);
        run_case(v, 1'b0, 32'h1);
        v = '{32'd5, 32'd3, 32'd5, 32'd1, 32'd3, 32'hFFFF_FFFF, 32'd0, 32'd1};
        run_case(v, 1'b0, 32'h3);
        run_case(v, 1'b1, 32'h1);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                v[i] = (r < 4) ? 32'($urandom_range(0, 15)) : 32'($urandom());
            end
            run_case(v, r[0], (r == 2) ? 32'h3 : 32'h1);
        end

        // Reset asserted between clock edges in the middle of a sort.
        for (int i = 0; i < DEPTH; i++) bus_write(4'(i), 32'(100 - i));
        bus_write(c_A_CTRL, 32'h1);
        repeat (10) idle_cycle();
        bus_read(c_A_SWAPS, 32'h0 + 32'(0));
        #2;
        reset = 1'b1;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'h0);
        check("midrst_done", {31'b0, done}, 32'h0);
        check("midrst_readdata", readdata, 32'h0);
`ifdef SORT_IRQ_EN
        check("midrst_irq", {31'b0, irq}, 32'h0);
`endif
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle_cycle();
        bus_read(c_A_STATUS, 32'h0);
        bus_read(c_A_SWAPS, 32'h0);
        for (int i = 0; i < DEPTH; i++) bus_read(4'(i), 32'h0);

        repeat (3) idle_cycle();
        if (rq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL rd_missing got=%0d exp=0", rq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
